// File: rtl/ysyx_25020037_wbu.sv
// Write-back stage: takes one LSU result, aligns/extends load data, drives the
// register-file write port and holds a commit record until the IFU accepts it.
module ysyx_25020037_wbu #(
  parameter logic [3:0] LOAD_FAULT_CAUSE  = 4'd5,
  parameter logic [3:0] STORE_FAULT_CAUSE = 4'd7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_valid_i,
  output logic        wbu_ready_o,
  input  logic [63:0] lu_to_wu_bus_i,
  input  logic        access_fault_i,
  input  logic [79:0] du_to_wu_bus_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        wbu_valid_o,
  input  logic        ifu_ready_i,
  output logic [31:0] commit_pc_o,
  output logic [31:0] commit_dnpc_o,
  output logic        trap_valid_o,
  output logic [3:0]  trap_cause_o,
  output logic [31:0] trap_tval_o
);

  typedef enum logic {IDLE, COMMIT} state_e;

  state_e      state_q;
  logic        wbu_ready_q, wbu_valid_q, rf_we_q, trap_valid_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q, commit_pc_q, commit_dnpc_q, trap_tval_q;
  logic [3:0]  trap_cause_q;

  logic [31:0] addr, rdata, pc, dnpc;
  logic [4:0]  rd;
  logic        reg_we, is_load, load_unsigned, is_store;
  logic [2:0]  load_op;

  assign addr          = lu_to_wu_bus_i[63:32];
  assign rdata         = lu_to_wu_bus_i[31:0];
  assign pc            = du_to_wu_bus_i[79:48];
  assign dnpc          = du_to_wu_bus_i[47:16];
  assign rd            = du_to_wu_bus_i[15:11];
  assign reg_we        = du_to_wu_bus_i[10];
  assign is_load       = du_to_wu_bus_i[9];
  assign load_op       = du_to_wu_bus_i[8:6];
  assign load_unsigned = du_to_wu_bus_i[5];
  assign is_store      = du_to_wu_bus_i[4];

  logic unused_reserved;
  assign unused_reserved = ^du_to_wu_bus_i[3:0];

  logic [31:0] shifted, load_data, rf_wdata_d;
  logic        fault_d, rf_we_d;
  logic [3:0]  trap_cause_d;

  always_comb begin
    shifted = rdata >> {addr[1:0], 3'b000};
    // Anything other than a clean byte/half one-hot falls back to a word load.
    case (load_op)
      3'b001:  load_data = {{24{~load_unsigned & shifted[7]}}, shifted[7:0]};
      3'b010:  load_data = {{16{~load_unsigned & shifted[15]}}, shifted[15:0]};
      default: load_data = rdata;
    endcase
    rf_wdata_d   = is_load ? load_data : rdata;
    fault_d      = access_fault_i & (is_load | is_store);
    rf_we_d      = reg_we & (rd != 5'd0) & ~fault_d;
    trap_cause_d = is_load ? LOAD_FAULT_CAUSE : STORE_FAULT_CAUSE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      wbu_ready_q   <= 1'b1;
      wbu_valid_q   <= 1'b0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= 5'd0;
      rf_wdata_q    <= 32'd0;
      commit_pc_q   <= 32'd0;
      commit_dnpc_q <= 32'd0;
      trap_valid_q  <= 1'b0;
      trap_cause_q  <= 4'd0;
      trap_tval_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lsu_valid_i && wbu_ready_q) begin
            state_q       <= COMMIT;
            wbu_ready_q   <= 1'b0;
            wbu_valid_q   <= 1'b1;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rd;
            rf_wdata_q    <= rf_wdata_d;
            commit_pc_q   <= pc;
            commit_dnpc_q <= dnpc;
            trap_valid_q  <= fault_d;
            trap_cause_q  <= trap_cause_d;
            trap_tval_q   <= addr;
          end
        end
        COMMIT: begin
          // Write strobe lasts only the first commit cycle, even if the IFU stalls.
          rf_we_q <= 1'b0;
          if (wbu_valid_q && ifu_ready_i) begin
            state_q      <= IDLE;
            wbu_valid_q  <= 1'b0;
            trap_valid_q <= 1'b0;
            wbu_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbu_ready_o   = wbu_ready_q;
  assign wbu_valid_o   = wbu_valid_q;
  assign rf_we_o       = rf_we_q;
  assign rf_waddr_o    = rf_waddr_q;
  assign rf_wdata_o    = rf_wdata_q;
  assign commit_pc_o   = commit_pc_q;
  assign commit_dnpc_o = commit_dnpc_q;
  assign trap_valid_o  = trap_valid_q;
  assign trap_cause_o  = trap_cause_q;
  assign trap_tval_o   = trap_tval_q;

endmodule

// File: tb/tb_ysyx_25020037_wbu.sv
// Directed bench for the write-back stage: vector table plus stall and reset sequences.
module tb_ysyx_25020037_wbu;

  logic        clk = 1'b0;
  logic        rst, lsu_valid, access_fault, ifu_ready;
  logic [63:0] lu_bus;
  logic [79:0] du_bus;
  logic        wbu_ready, rf_we, wbu_valid, trap_valid;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, commit_pc, commit_dnpc, trap_tval;
  logic [3:0]  trap_cause;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_25020037_wbu dut (
    .clk_i(clk), .rst_i(rst), .lsu_valid_i(lsu_valid), .wbu_ready_o(wbu_ready),
    .lu_to_wu_bus_i(lu_bus), .access_fault_i(access_fault), .du_to_wu_bus_i(du_bus),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .wbu_valid_o(wbu_valid), .ifu_ready_i(ifu_ready),
    .commit_pc_o(commit_pc), .commit_dnpc_o(commit_dnpc),
    .trap_valid_o(trap_valid), .trap_cause_o(trap_cause), .trap_tval_o(trap_tval)
  );

  typedef struct {
    logic [31:0] addr, rdata, pc, dnpc;
    logic [4:0]  rd;
    logic        reg_we, is_load;
    logic [2:0]  lop;
    logic        lu, is_st, fault;
    logic        exp_we;
    logic [31:0] exp_wd;
    logic        exp_tv;
    logic [3:0]  exp_tc;
  } vec_t;

  vec_t v[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    lsu_valid    = 1'b1;
    lu_bus       = {t.addr, t.rdata};
    du_bus       = {t.pc, t.dnpc, t.rd, t.reg_we, t.is_load, t.lop, t.lu, t.is_st, 4'hA};
    access_fault = t.fault;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t x, y;

  initial begin
    v[0]  = '{32'h80000003, 32'h80FF1234, 32'h80000000, 32'h80000004, 5'd5,  1, 1, 3'b001, 0, 0, 0, 1, 32'hFFFFFF80, 0, 4'd0};
    v[1]  = '{32'h80000002, 32'hBEEF0000, 32'h80000004, 32'h80000008, 5'd6,  1, 1, 3'b010, 1, 0, 0, 1, 32'h0000BEEF, 0, 4'd0};
    v[2]  = '{32'h80000002, 32'hBEEF0000, 32'h80000008, 32'h8000000C, 5'd7,  1, 1, 3'b010, 0, 0, 0, 1, 32'hFFFFBEEF, 0, 4'd0};
    v[3]  = '{32'h10000004, 32'h00000000, 32'h80000100, 32'h80000104, 5'd0,  0, 0, 3'b100, 0, 1, 1, 0, 32'h0,        1, 4'd7};
    v[4]  = '{32'h20000000, 32'h11111111, 32'h80000108, 32'h8000010C, 5'd3,  1, 1, 3'b100, 0, 0, 1, 0, 32'h0,        1, 4'd5};
    v[5]  = '{32'h00000000, 32'h00001234, 32'h80000110, 32'h80000114, 5'd0,  1, 0, 3'b000, 0, 0, 0, 0, 32'h0,        0, 4'd0};
    v[6]  = '{32'h80000001, 32'h12345678, 32'h80000118, 32'h8000011C, 5'd9,  1, 1, 3'b001, 1, 0, 0, 1, 32'h00000056, 0, 4'd0};
    v[7]  = '{32'h80000003, 32'h80FF1234, 32'h80000120, 32'h80000124, 5'd10, 1, 1, 3'b010, 0, 0, 0, 1, 32'h00000080, 0, 4'd0};
    v[8]  = '{32'h80000002, 32'hCAFEBABE, 32'h80000128, 32'h8000012C, 5'd11, 1, 1, 3'b011, 0, 0, 0, 1, 32'hCAFEBABE, 0, 4'd0};
    v[9]  = '{32'h00000001, 32'hDEADBEEF, 32'h80000130, 32'h90000000, 5'd31, 1, 0, 3'b000, 0, 0, 0, 1, 32'hDEADBEEF, 0, 4'd0};
    v[10] = '{32'h30000008, 32'h00000000, 32'h80000138, 32'h8000013C, 5'd0,  0, 0, 3'b100, 0, 1, 0, 0, 32'h0,        0, 4'd0};

    rst = 1'b1; lsu_valid = 1'b0; access_fault = 1'b0; ifu_ready = 1'b0;
    lu_bus = '0; du_bus = '0;
    tick(); tick();
    chk("rst.wbu_ready", 32'(wbu_ready), 32'd1);
    chk("rst.wbu_valid", 32'(wbu_valid), 32'd0);
    chk("rst.rf_we", 32'(rf_we), 32'd0);
    chk("rst.rf_wdata", rf_wdata, 32'd0);
    chk("rst.commit_pc", commit_pc, 32'd0);
    chk("rst.trap_valid", 32'(trap_valid), 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(v[i]);
      ifu_ready = 1'b1;
      tick();
      chk($sformatf("v%0d.wbu_valid", i), 32'(wbu_valid), 32'd1);
      chk($sformatf("v%0d.wbu_ready", i), 32'(wbu_ready), 32'd0);
      chk($sformatf("v%0d.rf_we", i), 32'(rf_we), 32'(v[i].exp_we));
      if (v[i].exp_we) begin
        chk($sformatf("v%0d.rf_waddr", i), 32'(rf_waddr), 32'(v[i].rd));
        chk($sformatf("v%0d.rf_wdata", i), rf_wdata, v[i].exp_wd);
      end
      chk($sformatf("v%0d.trap_valid", i), 32'(trap_valid), 32'(v[i].exp_tv));
      if (v[i].exp_tv) begin
        chk($sformatf("v%0d.trap_cause", i), 32'(trap_cause), 32'(v[i].exp_tc));
        chk($sformatf("v%0d.trap_tval", i), trap_tval, v[i].addr);
      end
      chk($sformatf("v%0d.commit_pc", i), commit_pc, v[i].pc);
      chk($sformatf("v%0d.commit_dnpc", i), commit_dnpc, v[i].dnpc);
      @(negedge clk);
      lsu_valid = 1'b0; access_fault = 1'b0;
      tick();
      chk($sformatf("v%0d.post.wbu_valid", i), 32'(wbu_valid), 32'd0);
      chk($sformatf("v%0d.post.wbu_ready", i), 32'(wbu_ready), 32'd1);
      chk($sformatf("v%0d.post.rf_we", i), 32'(rf_we), 32'd0);
      chk($sformatf("v%0d.post.trap_valid", i), 32'(trap_valid), 32'd0);
    end

    // IFU stall with the LSU offering a second result the whole time.
    x = '{32'h00000000, 32'h00000055, 32'h80000200, 32'h80000204, 5'd7, 1, 0, 3'b000, 0, 0, 0, 1, 32'h55, 0, 4'd0};
    y = '{32'h00000000, 32'h00000066, 32'h80000204, 32'h80000208, 5'd8, 1, 0, 3'b000, 0, 0, 0, 1, 32'h66, 0, 4'd0};
    @(negedge clk);
    drive(x);
    ifu_ready = 1'b0;
    tick();
    chk("stall.first.rf_we", 32'(rf_we), 32'd1);
    chk("stall.first.rf_waddr", 32'(rf_waddr), 32'd7);
    @(negedge clk);
    drive(y);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall.c%0d.wbu_valid", c), 32'(wbu_valid), 32'd1);
      chk($sformatf("stall.c%0d.wbu_ready", c), 32'(wbu_ready), 32'd0);
      chk($sformatf("stall.c%0d.commit_pc", c), commit_pc, 32'h80000200);
      tick();
      chk($sformatf("stall.c%0d.rf_we", c), 32'(rf_we), 32'd0);
    end
    chk("stall.c3.wbu_valid", 32'(wbu_valid), 32'd1);
    chk("stall.c3.commit_pc", commit_pc, 32'h80000200);
    chk("stall.c3.rf_wdata", rf_wdata, 32'h55);
    @(negedge clk); ifu_ready = 1'b1;
    tick();
    chk("stall.hs.wbu_valid", 32'(wbu_valid), 32'd0);
    chk("stall.hs.wbu_ready", 32'(wbu_ready), 32'd1);
    tick();
    chk("stall.second.wbu_valid", 32'(wbu_valid), 32'd1);
    chk("stall.second.rf_we", 32'(rf_we), 32'd1);
    chk("stall.second.rf_waddr", 32'(rf_waddr), 32'd8);
    chk("stall.second.commit_pc", commit_pc, 32'h80000204);
    @(negedge clk); lsu_valid = 1'b0;
    tick();
    chk("stall.end.wbu_valid", 32'(wbu_valid), 32'd0);

    // Reset arriving while a record is pending.
    @(negedge clk);
    drive(v[0]);
    ifu_ready = 1'b0;
    tick();
    chk("rstmid.accepted", 32'(wbu_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1; lsu_valid = 1'b0;
    tick();
    chk("rstmid.wbu_valid", 32'(wbu_valid), 32'd0);
    chk("rstmid.wbu_ready", 32'(wbu_ready), 32'd1);
    chk("rstmid.rf_we", 32'(rf_we), 32'd0);
    chk("rstmid.rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rstmid.rf_wdata", rf_wdata, 32'd0);
    chk("rstmid.commit_pc", commit_pc, 32'd0);
    chk("rstmid.commit_dnpc", commit_dnpc, 32'd0);
    chk("rstmid.trap_tval", trap_tval, 32'd0);
    @(negedge clk); rst = 1'b0; ifu_ready = 1'b1;
    tick();
    chk("rstmid.after.wbu_valid", 32'(wbu_valid), 32'd0);
    chk("rstmid.after.rf_we", 32'(rf_we), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25020037_wbu.md
Name: ysyx_25020037_wbu

Overview:
Write-back stage of the multi-cycle core; sits directly downstream of the LSU and consumes its result bus under a valid/ready handshake. It aligns and sign- or zero-extends load data and drives the register-file write port. It reports load and store access faults as a trap, then presents one commit record per instruction to the IFU and holds it until the IFU accepts.

Parameters:
LOAD_FAULT_CAUSE, 4'd5, trap_cause value for a load access fault
STORE_FAULT_CAUSE, 4'd7, trap_cause value for a store access fault

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  reset; one clock, synchronous, active-high
lsu_valid  in  1  LSU result valid
wbu_ready  out  1  WBU can accept an LSU result
lu_to_wu_bus  in  64  [63:32] effective address / ALU result; [31:0] raw load data or ALU result
access_fault  in  1  bus error on this LSU transaction; qualified by lsu_valid
du_to_wu_bus  in  80  [79:48] pc; [47:16] dnpc; [15:11] rd; [10] reg_we; [9] is_load; [8:6] load_op one-hot (001 byte, 010 half, 100 word); [5] load_unsigned; [4] is_store; [3:0] reserved, ignored
rf_we  out  1  register-file write strobe
rf_waddr  out  5  destination register
rf_wdata  out  32  write data
wbu_valid  out  1  commit record valid to IFU
ifu_ready  in  1  IFU accepts commit
commit_pc  out  32  pc of committed instruction
commit_dnpc  out  32  next pc of committed instruction
trap_valid  out  1  committed instruction faulted; qualified by wbu_valid
trap_cause  out  4  fault cause
trap_tval  out  32  faulting address

Behaviour:
- Reset values (synchronous): state=IDLE, wbu_ready=1, wbu_valid=0, rf_we=0, rf_waddr=0, rf_wdata=0, commit_pc=0, commit_dnpc=0, trap_valid=0, trap_cause=0, trap_tval=0.
- States: IDLE and COMMIT.
- IDLE -> COMMIT on accept, where accept = lsu_valid & wbu_ready sampled at edge N.
  - At edge N, latch both buses and access_fault; set wbu_ready=0.
- Cycle N+1 (first COMMIT cycle):
  - rf_we=1 for exactly one cycle when reg_we & (rd!=0) & !access_fault.
  - wbu_valid=1 with commit_pc, commit_dnpc and trap fields valid.
- COMMIT -> IDLE at the first edge where wbu_valid & ifu_ready.
  - On that edge: wbu_valid=0, trap_valid=0, wbu_ready=1.
  - Minimum accept-to-accept spacing is 2 cycles.
- While in COMMIT, lsu_valid is ignored; wbu_ready stays 0.
- rf_waddr and rf_wdata are registered and hold until the next accept.
- Load extension applies when is_load=1, with off=addr[1:0] and sh = rdata >> (8*off):
  - byte: {24{~load_unsigned & sh[7]}, sh[7:0]}
  - half: {16{~load_unsigned & sh[15]}, sh[15:0]}; off=3 yields sh[15:8]=0, no fault raised here.
  - word: rdata unshifted.
  - load_op not one-hot: treated as word.
- Non-load: rf_wdata = lu_to_wu_bus[31:0].
- Fault handling:
  - trap_valid = latched access_fault & (is_load | is_store).
  - trap_cause = LOAD_FAULT_CAUSE if is_load, else STORE_FAULT_CAUSE.
  - trap_tval = lu_to_wu_bus[63:32]; commit_dnpc is passed unchanged (IFU redirects on trap).
  - access_fault on a non-memory instruction is ignored.
- rd=0 never produces rf_we=1, regardless of reg_we.
- Reset asserted mid-COMMIT: next edge returns to reset values; the pending record is dropped with no rf_we or commit.
- rf_we, wbu_valid and wbu_ready are never combinationally dependent on inputs.

Test Plan:
- lb at addr 0x80000003, rdata 0x80FF1234, rd=5 -> rf_we one cycle, rf_waddr=5, rf_wdata=0xFFFFFF80; wbu_valid asserted the same cycle.
- lhu at addr 0x80000002, rdata 0xBEEF0000 -> rf_wdata=0x0000BEEF; lh with the same inputs -> 0xFFFFBEEF.
- sw with access_fault=1, addr 0x10000004, pc 0x80000100 -> rf_we=0, trap_valid=1, trap_cause=7, trap_tval=0x10000004, commit_pc=0x80000100; a faulting lw -> trap_cause=5, no rf_we.
- ALU op rd=0, reg_we=1, data 0x1234 -> rf_we stays 0, commit still occurs.
- ifu_ready held low 3 cycles after wbu_valid rises, lsu_valid held high -> wbu_valid stable 4 cycles with record unchanged; wbu_ready=0 throughout; second instruction accepted only the cycle after the commit handshake; rf_we pulses once per instruction.
- rst=1 in the cycle after accept -> next cycle all outputs at reset values; no commit; wbu_ready=1.
